// File: rtl/gshare_predictor.sv
// Gshare branch predictor: table of saturating counters indexed by address, optionally
// XORed with a speculative global history register that is repaired on mispredicts.
module gshare_predictor #(
   parameter int IDX_W  = 5,
   parameter int CTR_W  = 2,
   parameter int HIST_W = 5,
   parameter int GSHARE = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              predValid_i,
   input  logic [IDX_W-1:0]  predAddr_i,
   output logic              predTaken_o,
   output logic [HIST_W-1:0] predHist_o,
   input  logic              updValid_i,
   input  logic [IDX_W-1:0]  updAddr_i,
   input  logic [HIST_W-1:0] updHist_i,
   input  logic              updTaken_i,
   input  logic              updMispredict_i
);

   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_MIN  = '0;
   localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

   if (HIST_W < 1 || HIST_W > IDX_W) begin : gBadHistWidth
      $error("gshare_predictor: HIST_W must satisfy 1 <= HIST_W <= IDX_W");
   end

   logic [CTR_W-1:0]  ctrTable [DEPTH];
   logic [HIST_W-1:0] ghr;
   logic [IDX_W-1:0]  rIdx;
   logic [IDX_W-1:0]  wIdx;
   logic [CTR_W-1:0]  ctrCur;
   logic [CTR_W-1:0]  ctrNext;
   logic [HIST_W-1:0] ghrShifted;
   logic [HIST_W-1:0] ghrRepaired;

   // History is zero-extended into the index; bimodal mode keeps the GHR alive but unused.
   always_comb begin
      if (GSHARE != 0) begin
         rIdx = predAddr_i ^ IDX_W'(ghr);
         wIdx = updAddr_i ^ IDX_W'(updHist_i);
      end else begin
         rIdx = predAddr_i;
         wIdx = updAddr_i;
      end
   end

   assign predTaken_o = ctrTable[rIdx][CTR_W-1];
   assign predHist_o  = ghr;

   always_comb begin
      ctrCur  = ctrTable[wIdx];
      ctrNext = ctrCur;
      if (updTaken_i) begin
         if (ctrCur != CTR_MAX) ctrNext = ctrCur + CTR_ONE;
      end else begin
         if (ctrCur != CTR_MIN) ctrNext = ctrCur - CTR_ONE;
      end
   end

   // Truncating the concatenation drops the oldest bit and also covers HIST_W == 1.
   assign ghrShifted  = HIST_W'({ghr, predTaken_o});
   assign ghrRepaired = HIST_W'({updHist_i, updTaken_i});

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) ctrTable[i] <= CTR_INIT;
      end else if (updValid_i) begin
         ctrTable[wIdx] <= ctrNext;
      end
   end

   // A mispredict repair overrides any speculative shift issued in the same cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ghr <= '0;
      end else if (updValid_i && updMispredict_i) begin
         ghr <= ghrRepaired;
      end else if (predValid_i) begin
         ghr <= ghrShifted;
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: one gshare instance and one bimodal instance
// share the same stimulus; expected values are hand-derived per step.
module tb_gshare_predictor;

   logic       clk = 1'b0;
   logic       rst;
   logic       predValid;
   logic [4:0] predAddr;
   logic       updValid;
   logic [4:0] updAddr;
   logic [4:0] updHist;
   logic       updTaken;
   logic       updMispredict;

   logic       predTakenG;
   logic [4:0] predHistG;
   logic       predTakenB;
   logic [4:0] predHistB;

   int checks = 0;
   int errors = 0;

   gshare_predictor #(.IDX_W(5), .CTR_W(2), .HIST_W(5), .GSHARE(1)) dutG (
      .clk_i(clk), .reset_i(rst),
      .predValid_i(predValid), .predAddr_i(predAddr),
      .predTaken_o(predTakenG), .predHist_o(predHistG),
      .updValid_i(updValid), .updAddr_i(updAddr), .updHist_i(updHist),
      .updTaken_i(updTaken), .updMispredict_i(updMispredict)
   );

   gshare_predictor #(.IDX_W(5), .CTR_W(2), .HIST_W(5), .GSHARE(0)) dutB (
      .clk_i(clk), .reset_i(rst),
      .predValid_i(predValid), .predAddr_i(predAddr),
      .predTaken_o(predTakenB), .predHist_o(predHistB),
      .updValid_i(updValid), .updAddr_i(updAddr), .updHist_i(updHist),
      .updTaken_i(updTaken), .updMispredict_i(updMispredict)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic pv, input logic [4:0] pa,
                                input logic uv, input logic [4:0] ua,
                                input logic [4:0] uh, input logic ut, input logic um);
      predValid     = pv;
      predAddr      = pa;
      updValid      = uv;
      updAddr       = ua;
      updHist       = uh;
      updTaken      = ut;
      updMispredict = um;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("duringResetTaken", predTakenG, 0);
      repeat (2) tick();
      rst = 1'b0;
      #1;

      // Reset state across every address, both modes
      for (int a = 0; a < 32; a++) begin
         applyStimulus(0, 5'(a), 0, 0, 0, 0, 0);
         checkOutput($sformatf("resetTakenG[%0d]", a), predTakenG, 0);
         checkOutput($sformatf("resetHistG[%0d]", a), predHistG, 0);
         checkOutput($sformatf("resetTakenB[%0d]", a), predTakenB, 0);
      end

      // Bimodal: addr 3 taken x3, then not-taken x3; addr 4 untouched
      applyStimulus(0, 3, 1, 3, 0, 1, 0);
      tick();
      checkOutput("bimT1", predTakenB, 1);
      applyStimulus(0, 4, 1, 3, 0, 1, 0);
      checkOutput("bimAddr4a", predTakenB, 0);
      tick();
      tick();
      applyStimulus(0, 3, 0, 0, 0, 0, 0);
      checkOutput("bimT3sat", predTakenB, 1);
      applyStimulus(0, 3, 1, 3, 0, 0, 0);
      tick();
      checkOutput("bimN1", predTakenB, 1);
      tick();
      checkOutput("bimN2", predTakenB, 0);
      tick();
      applyStimulus(0, 3, 0, 0, 0, 0, 0);
      checkOutput("bimN3", predTakenB, 0);
      applyStimulus(0, 4, 0, 0, 0, 0, 0);
      checkOutput("bimAddr4b", predTakenB, 0);
      checkOutput("bimHist", predHistB, 0);

      // Async reset between edges clears the trained entry
      applyStimulus(0, 3, 1, 3, 0, 1, 0);
      tick();
      tick();
      applyStimulus(0, 3, 0, 0, 0, 0, 0);
      checkOutput("bimRetrain", predTakenB, 1);
      pulseReset();
      checkOutput("bimAfterReset", predTakenB, 0);

      // Gshare: train idx 0, predict addr 0, GHR shifts in a 1
      applyStimulus(0, 0, 1, 0, 0, 1, 0);
      tick();
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("gsPredTaken", predTakenG, 1);
      checkOutput("gsPredHist", predHistG, 0);
      tick();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("gsGhr1", predHistG, 5'b00001);
      checkOutput("gsXorIdx", predTakenG, 1);

      // Two more taken predictions bring GHR to 00111
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 3, 0, 0, 0, 0, 0);
      checkOutput("gsGhr3", predHistG, 5'b00011);
      checkOutput("gsPred3", predTakenG, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("gsGhr7", predHistG, 5'b00111);

      // Repair wins over a same-cycle speculative shift
      applyStimulus(1, 7, 1, 0, 5'b00010, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("gsRepair", predHistG, 5'b00100);

      // Mispredict without updValid is ignored
      applyStimulus(0, 0, 0, 0, 5'b11111, 1, 1);
      tick();
      checkOutput("gsMispIgnored", predHistG, 5'b00100);

      // Same-index read/write: old value this cycle, new value next cycle
      applyStimulus(0, 1, 1, 1, 5'b00100, 1, 0);
      checkOutput("hazardG0", predTakenG, 0);
      checkOutput("hazardB0", predTakenB, 0);
      tick();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("hazardG1", predTakenG, 1);
      checkOutput("hazardB1", predTakenB, 1);

      // Async reset mid-operation, update on the reset edge is lost
      applyStimulus(0, 1, 1, 5, 0, 1, 0);
      rst = 1'b1;
      #1;
      checkOutput("midResetTaken", predTakenG, 0);
      checkOutput("midResetHist", predHistG, 0);
      tick();
      rst = 1'b0;
      applyStimulus(0, 5, 0, 0, 0, 0, 0);
      checkOutput("lostUpdate", predTakenG, 0);
      applyStimulus(0, 5, 1, 5, 0, 1, 0);
      tick();
      applyStimulus(0, 5, 0, 0, 0, 0, 0);
      checkOutput("resumeG", predTakenG, 1);
      checkOutput("resumeB", predTakenB, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
